// File: rtl/ad9361_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ad9361_ctrl_pkg
// Shared definitions for the AD9361 ENSM pin-control sequencer.
//   mode_e       : requested transceiver mode (IDLE/ALERT, RX, TX, FDD)
//   state_e      : sequencer FSM state encoding (readable on the state pins)
//   txnrx_target : TXNRX pin level required by a mode
//   max_u        : max of two unsigned values
//   cnt_width    : counter width able to hold a given maximum value
// ---------------------------------------------------------------------------
package ad9361_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_IDLE = 2'b00,
      MODE_RX   = 2'b01,
      MODE_TX   = 2'b10,
      MODE_FDD  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ACTIVE = 3'd2,
      S_DROP   = 3'd3,
      S_MCS    = 3'd4
   } state_e;

   // IDLE has no direction of its own, so TXNRX keeps whatever it was.
   function automatic logic txnrx_target(input mode_e mode, input logic cur);
      logic res;
      case (mode)
         MODE_RX:           res = 1'b0;
         MODE_TX, MODE_FDD: res = 1'b1;
         default:           res = cur;
      endcase
      return res;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned maxv);
      return (maxv < 1) ? 1 : $clog2(maxv + 1);
   endfunction

endpackage

// File: rtl/ad9361_ensm_ctrl_if.sv
// ---------------------------------------------------------------------------
// ad9361_ensm_ctrl_if
// Control-side handshake between the PS register/GPIO path and the sequencer.
//   req_valid/req_ready/req_mode : mode request handshake
//   mcs_req                      : single-cycle MCS start pulse
//   mcs_busy                     : MCS pulse train in progress
// master = requester (PS side), slave = sequencer.
// ---------------------------------------------------------------------------
interface ad9361_ensm_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_mode;
   logic       mcs_req;
   logic       mcs_busy;

   modport master (
      output req_valid, req_mode, mcs_req,
      input  req_ready, mcs_busy
   );

   modport slave (
      input  req_valid, req_mode, mcs_req,
      output req_ready, mcs_busy
   );
endinterface

// File: rtl/ad9361_mcs_pulse_gen.sv
// ---------------------------------------------------------------------------
// ad9361_mcs_pulse_gen
// Generates PULSES sync pulses, each PULSE_W cycles high, separated by GAP
// low cycles, no trailing gap. Only instantiated when AD9361_MCS_EN is defined.
//   clk, rstn : clock, asynchronous active-low reset
//   i_start   : start a train (ignored while busy)
//   o_busy    : registered, high from the cycle after start to the last high cycle
//   o_sync    : registered sync pin level
//   o_last    : combinational, high in the final high cycle of the train
// ---------------------------------------------------------------------------
module ad9361_mcs_pulse_gen
   import ad9361_ctrl_pkg::*;
#(
   parameter int unsigned PULSES  = 2,
   parameter int unsigned PULSE_W = 8,
   parameter int unsigned GAP     = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_start,
   output logic o_busy,
   output logic o_sync,
   output logic o_last
);

   localparam int unsigned CntW  = cnt_width(max_u(PULSE_W, GAP));
   localparam int unsigned LeftW = cnt_width(PULSES);

   logic             r_busy, w_busy_nxt;
   logic             r_sync, w_sync_nxt;
   logic [CntW-1:0]  r_cnt, w_cnt_nxt;
   logic [LeftW-1:0] r_left, w_left_nxt;
   logic             w_cnt_exp;

   // Counts down to 1; a zero count (e.g. zero-length phase) also expires.
   assign w_cnt_exp = (r_cnt <= CntW'(1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy <= 1'b0;
         r_sync <= 1'b0;
         r_cnt  <= '0;
         r_left <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_sync <= w_sync_nxt;
         r_cnt  <= w_cnt_nxt;
         r_left <= w_left_nxt;
      end
   end

   always_comb begin
      w_busy_nxt = r_busy;
      w_sync_nxt = r_sync;
      w_left_nxt = r_left;
      w_cnt_nxt  = r_cnt;
      if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - CntW'(1);
      end
      if (i_start && !r_busy) begin
         w_busy_nxt = 1'b1;
         w_sync_nxt = 1'b1;
         w_cnt_nxt  = CntW'(PULSE_W);
         w_left_nxt = LeftW'(PULSES);
      end else if (r_busy && w_cnt_exp) begin
         if (r_sync) begin
            // End of a high phase: finish or start a gap.
            w_sync_nxt = 1'b0;
            if (r_left <= LeftW'(1)) begin
               w_busy_nxt = 1'b0;
               w_left_nxt = '0;
            end else begin
               w_cnt_nxt  = CntW'(GAP);
               w_left_nxt = r_left - LeftW'(1);
            end
         end else begin
            w_sync_nxt = 1'b1;
            w_cnt_nxt  = CntW'(PULSE_W);
         end
      end
   end

   assign o_busy = r_busy;
   assign o_sync = r_sync;
   assign o_last = r_busy && r_sync && w_cnt_exp && (r_left <= LeftW'(1));

endmodule

// File: rtl/ad9361_ensm_ctrl.sv
// ---------------------------------------------------------------------------
// ad9361_ensm_ctrl
// Pin-control ENSM sequencer for two AD9361 transceivers. Turns mode requests
// into ordered ENABLE/TXNRX pin levels with TXNRX setup and ENABLE-low hold
// guard times; optionally drives the MCS sync pulse train from IDLE.
// Optional feature macro: AD9361_MCS_EN (MCS state + pulse generator).
// Ports:
//   clk, rstn           : clock, asynchronous active-low reset
//   ctrl (slave)        : req_valid/req_ready/req_mode, mcs_req, mcs_busy
//   enable_0, enable_1  : ENABLE pins (chip 1 mirrors chip 0)
//   txnrx_0, txnrx_1    : TXNRX pins (chip 1 mirrors chip 0)
//   mcs_sync            : MCS sync pin
//   state               : current FSM state for status readback
// ---------------------------------------------------------------------------
module ad9361_ensm_ctrl
   import ad9361_ctrl_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned HOLD_CYCLES  = 4,
   parameter int unsigned MCS_PULSES   = 2,
   parameter int unsigned MCS_PULSE_W  = 8,
   parameter int unsigned MCS_GAP      = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   ad9361_ensm_ctrl_if.slave        ctrl,
   output logic                     enable_0,
   output logic                     enable_1,
   output logic                     txnrx_0,
   output logic                     txnrx_1,
   output logic                     mcs_sync,
   output logic [2:0]               state
);

   localparam int unsigned CntW = cnt_width(max_u(GUARD_CYCLES, HOLD_CYCLES));

   state_e          r_state, w_state_nxt;
   logic [CntW-1:0] r_cnt, w_cnt_nxt;
   mode_e           r_mode, w_mode_nxt;
   mode_e           r_pend, w_pend_nxt;
   logic            r_enable, w_enable_nxt;
   logic            r_txnrx, w_txnrx_nxt;
   logic            r_ready, w_ready_nxt;
   mode_e           w_req_mode;
   logic            w_accept;
   logic            w_cnt_exp;

`ifdef AD9361_MCS_EN
   logic w_mcs_start;
   logic w_mcs_last;
   logic w_mcs_busy;
   logic w_mcs_sync;
`endif

   assign w_req_mode = mode_e'(ctrl.req_mode);
   assign w_accept   = ctrl.req_valid && r_ready;
   assign w_cnt_exp  = (r_cnt <= CntW'(1));

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_mode   <= MODE_IDLE;
         r_pend   <= MODE_IDLE;
         r_enable <= 1'b0;
         r_txnrx  <= 1'b0;
         r_ready  <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_mode   <= w_mode_nxt;
         r_pend   <= w_pend_nxt;
         r_enable <= w_enable_nxt;
         r_txnrx  <= w_txnrx_nxt;
         r_ready  <= w_ready_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_pend_nxt  = r_pend;
      w_cnt_nxt   = r_cnt;
`ifdef AD9361_MCS_EN
      w_mcs_start = 1'b0;
`endif
      // Saturating down-counter; loads below override the decrement.
      if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - CntW'(1);
      end
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_req_mode != MODE_IDLE) begin
                  w_state_nxt = S_SETUP;
                  w_mode_nxt  = w_req_mode;
                  w_cnt_nxt   = CntW'(GUARD_CYCLES);
               end
            end
`ifdef AD9361_MCS_EN
            // A simultaneous mode request takes priority; mcs_req is dropped.
            else if (ctrl.mcs_req) begin
               w_state_nxt = S_MCS;
               w_mcs_start = 1'b1;
            end
`endif
         end
         S_SETUP: begin
            if (w_cnt_exp) begin
               w_state_nxt = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (w_accept && (w_req_mode != r_mode)) begin
               w_state_nxt = S_DROP;
               w_pend_nxt  = w_req_mode;
               w_cnt_nxt   = CntW'(HOLD_CYCLES);
            end
         end
         S_DROP: begin
            if (w_cnt_exp) begin
               if (r_pend != MODE_IDLE) begin
                  w_state_nxt = S_SETUP;
                  w_mode_nxt  = r_pend;
                  w_cnt_nxt   = CntW'(GUARD_CYCLES);
               end else begin
                  w_state_nxt = S_IDLE;
                  w_mode_nxt  = MODE_IDLE;
               end
            end
         end
`ifdef AD9361_MCS_EN
         S_MCS: begin
            if (w_mcs_last) begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic: pins are registered, so decode from the next state.
   always_comb begin
      w_enable_nxt = (w_state_nxt == S_ACTIVE);
      w_ready_nxt  = (w_state_nxt == S_IDLE) || (w_state_nxt == S_ACTIVE);
      w_txnrx_nxt  = r_txnrx;
      // TXNRX only moves on entry to SETUP, i.e. while ENABLE is already low.
      if ((w_state_nxt == S_SETUP) && (r_state != S_SETUP)) begin
         w_txnrx_nxt = txnrx_target(w_mode_nxt, r_txnrx);
      end
   end

`ifdef AD9361_MCS_EN
   ad9361_mcs_pulse_gen #(
      .PULSES  (MCS_PULSES),
      .PULSE_W (MCS_PULSE_W),
      .GAP     (MCS_GAP)
   ) u_mcs_pulse_gen (
      .clk     (clk),
      .rstn    (rstn),
      .i_start (w_mcs_start),
      .o_busy  (w_mcs_busy),
      .o_sync  (w_mcs_sync),
      .o_last  (w_mcs_last)
   );

   assign mcs_sync      = w_mcs_sync;
   assign ctrl.mcs_busy = w_mcs_busy;
`else
   logic unused_mcs;
   assign unused_mcs = ctrl.mcs_req ^ (MCS_PULSES == 0) ^ (MCS_PULSE_W == 0) ^ (MCS_GAP == 0);

   assign mcs_sync      = 1'b0;
   assign ctrl.mcs_busy = 1'b0;
`endif

   assign ctrl.req_ready = r_ready;
   assign enable_0       = r_enable;
   assign enable_1       = r_enable;
   assign txnrx_0        = r_txnrx;
   assign txnrx_1        = r_txnrx;
   assign state          = r_state;

endmodule

// File: tb/tb_ad9361_ensm_ctrl.sv
module tb_ad9361_ensm_ctrl;

   logic clk  = 1'b0;
   logic rstn = 1'b0;

   ad9361_ensm_ctrl_if ctrl ();

   logic       en0, en1, tx0, tx1, sync;
   logic [2:0] st;

   ad9361_ensm_ctrl #(
      .GUARD_CYCLES (4),
      .HOLD_CYCLES  (4),
      .MCS_PULSES   (2),
      .MCS_PULSE_W  (8),
      .MCS_GAP      (16)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .ctrl     (ctrl),
      .enable_0 (en0),
      .enable_1 (en1),
      .txnrx_0  (tx0),
      .txnrx_1  (tx1),
      .mcs_sync (sync),
      .state    (st)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      logic [7:0] exp;
      string      nm;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Expected snapshot {state, enable, txnrx, req_ready, mcs_busy, mcs_sync}
   function automatic void push(input int c, input logic [2:0] s, input logic en,
                                input logic tx, input logic rdy, input logic bsy,
                                input logic sy, input string nm);
      exp_t e;
      e.cyc = c;
      e.exp = {s, en, tx, rdy, bsy, sy};
      e.nm  = nm;
      sb.push_back(e);
   endfunction

   // Monitor: samples on the falling edge and checks scheduled expectations.
   initial begin
      logic [7:0] act;
      forever begin
         @(negedge clk);
         act = {st, en0, tx0, ctrl.req_ready, ctrl.mcs_busy, sync};
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL %s: cycle %0d was never observed", sb[0].nm, sb[0].cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s @cyc %0d: got st=%0d en=%b tx=%b rdy=%b busy=%b sync=%b, want st=%0d en=%b tx=%b rdy=%b busy=%b sync=%b",
                        e.nm, cyc, act[7:5], act[4], act[3], act[2], act[1], act[0],
                        e.exp[7:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
            end
         end
         total++;
         if ({en1, tx1} !== {en0, tx0}) begin
            bad++;
            $display("FAIL chip1_mirror @cyc %0d: got en1=%b tx1=%b, want en=%b tx=%b",
                     cyc, en1, tx1, en0, tx0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of inputs; a returns the edge count of the sampling edge.
   task automatic accept(input logic [1:0] m, input logic v, input logic mr, output int a);
      @(negedge clk);
      #1;
      ctrl.req_valid = v;
      ctrl.req_mode  = m;
      ctrl.mcs_req   = mr;
      step();
      a = cyc;
      ctrl.req_valid = 1'b0;
      ctrl.mcs_req   = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 200) begin
         step();
         n++;
      end
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      int a;
      ctrl.req_valid = 1'b0;
      ctrl.req_mode  = 2'b00;
      ctrl.mcs_req   = 1'b0;

      // Reset state
      step();
      push(cyc, 3'd0, 0, 0, 1, 0, 0, "reset_state");
      push(cyc + 1, 3'd0, 0, 0, 1, 0, 0, "reset_state_hold");
      drain();
      @(negedge clk);
      #1;
      rstn = 1'b1;
      step();
      push(cyc, 3'd0, 0, 0, 1, 0, 0, "post_reset_idle");
      drain();

      // IDLE -> RX; a request during SETUP must be ignored
      accept(2'b01, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd1, 0, 0, 0, 0, 0, "rx_setup");
      push(a + 4, 3'd2, 1, 0, 1, 0, 0, "rx_active");
      push(a + 5, 3'd2, 1, 0, 1, 0, 0, "rx_active_hold");
      step();
      ctrl.req_valid = 1'b1;
      ctrl.req_mode  = 2'b10;
      step();
      ctrl.req_valid = 1'b0;
      drain();

      // ACTIVE RX -> TX
      accept(2'b10, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 0, 0, 0, 0, "rx_tx_drop");
      for (int k = 4; k < 8; k++) push(a + k, 3'd1, 0, 1, 0, 0, 0, "rx_tx_setup");
      push(a + 8, 3'd2, 1, 1, 1, 0, 0, "tx_active");
      drain();

      // Same mode again is a no-op
      accept(2'b10, 1, 0, a);
      for (int k = 0; k < 3; k++) push(a + k, 3'd2, 1, 1, 1, 0, 0, "same_mode_noop");
      drain();

      // ACTIVE TX -> IDLE, TXNRX holds
      accept(2'b00, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 1, 0, 0, 0, "tx_idle_drop");
      push(a + 4, 3'd0, 0, 1, 1, 0, 0, "idle_entered");
      drain();

      // IDLE -> FDD, then FDD -> RX
      accept(2'b11, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd1, 0, 1, 0, 0, 0, "fdd_setup");
      push(a + 4, 3'd2, 1, 1, 1, 0, 0, "fdd_active");
      drain();
      accept(2'b01, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 1, 0, 0, 0, "fdd_rx_drop");
      for (int k = 4; k < 8; k++) push(a + k, 3'd1, 0, 0, 0, 0, 0, "fdd_rx_setup");
      push(a + 8, 3'd2, 1, 0, 1, 0, 0, "rx_active2");
      drain();

      // Asynchronous reset during SETUP, then normal sequencing
      accept(2'b10, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 0, 0, 0, 0, "pre_rst_drop");
      push(a + 4, 3'd1, 0, 1, 0, 0, 0, "pre_rst_setup");
      while (cyc < a + 5) step();
      rstn = 1'b0;
      push(cyc, 3'd0, 0, 0, 1, 0, 0, "async_reset_setup");
      step();
      @(negedge clk);
      #1;
      rstn = 1'b1;
      accept(2'b10, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd1, 0, 1, 0, 0, 0, "post_rst_setup");
      push(a + 4, 3'd2, 1, 1, 1, 0, 0, "post_rst_active");
      drain();
      accept(2'b00, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 1, 0, 0, 0, "to_idle_drop");
      push(a + 4, 3'd0, 0, 1, 1, 0, 0, "to_idle");
      drain();

`ifdef AD9361_MCS_EN
      // MCS train: 8 high, 16 low, 8 high; second mcs_req mid-train ignored
      accept(2'b00, 0, 1, a);
      for (int k = 0; k < 32; k++)
         push(a + k, 3'd4, 0, 1, 0, 1, (k < 8 || k >= 24) ? 1'b1 : 1'b0, "mcs_train");
      push(a + 32, 3'd0, 0, 1, 1, 0, 0, "mcs_done_idle");
      while (cyc < a + 10) step();
      ctrl.mcs_req = 1'b1;
      step();
      ctrl.mcs_req = 1'b0;
      drain();

      // Asynchronous reset mid-MCS
      accept(2'b00, 0, 1, a);
      for (int k = 0; k < 3; k++) push(a + k, 3'd4, 0, 1, 0, 1, 1, "mcs_pre_rst");
      while (cyc < a + 3) step();
      rstn = 1'b0;
      push(cyc, 3'd0, 0, 0, 1, 0, 0, "async_reset_mcs");
      step();
      @(negedge clk);
      #1;
      rstn = 1'b1;
      accept(2'b10, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd1, 0, 1, 0, 0, 0, "post_mcs_rst_setup");
      push(a + 4, 3'd2, 1, 1, 1, 0, 0, "post_mcs_rst_active");
      drain();
      accept(2'b00, 1, 0, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd3, 0, 1, 0, 0, 0, "mcs_idle_drop");
      push(a + 4, 3'd0, 0, 1, 1, 0, 0, "mcs_idle");
      drain();
`else
      // MCS not built: mcs_req has no effect
      accept(2'b00, 0, 1, a);
      for (int k = 0; k < 6; k++) push(a + k, 3'd0, 0, 1, 1, 0, 0, "mcs_ignored");
      drain();
`endif

      // Mode request and mcs_req together in IDLE: the request wins
      accept(2'b01, 1, 1, a);
      for (int k = 0; k < 4; k++) push(a + k, 3'd1, 0, 0, 0, 0, 0, "req_beats_mcs_setup");
      push(a + 4, 3'd2, 1, 0, 1, 0, 0, "req_beats_mcs_active");
      drain();

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
